// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, instruction field
// positions, the operand-fetch FSM state type and the instruction decoder.
package cpu_pkg;

  // Opcodes recognised by the operand-fetch decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;  // first ALU-immediate opcode
  localparam logic [5:0] OP_LUI   = 6'h0F;  // last ALU-immediate opcode
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instruction field positions (MIPS format)
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    VALID
  } state_t;

  // Register usage of one instruction
  typedef struct packed {
    logic             has_dest;
    logic [REG_W-1:0] dest;
    logic             uses_rs;
    logic             uses_rt;
  } decode_t;

  function automatic decode_t decode_instr(input logic [31:0] ir);
    decode_t    d;
    logic [5:0] opc;
    opc        = ir[OPC_LSB +: OPC_W];
    d          = '0;
    d.uses_rs  = 1'b1;
    if (opc == OP_RTYPE) begin
      d.has_dest = 1'b1;
      d.dest     = ir[RD_LSB +: REG_W];
      d.uses_rt  = 1'b1;
    end else if ((opc >= OP_ADDI && opc <= OP_LUI) || opc == OP_LW) begin
      d.has_dest = 1'b1;
      d.dest     = ir[RT_LSB +: REG_W];
    end else if (opc == OP_SW || opc == OP_BEQ || opc == OP_BNE) begin
      d.uses_rt  = 1'b1;
    end else if (opc == OP_J) begin
      d.uses_rs  = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction that writes it leaves operand fetch, cleared on writeback.
module scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              uses_rs,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              uses_rt,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              check_dest,
  output logic              hazard
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] pend_next;

  // One-hot set/clear masks and the next pending vector
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    set_mask = '0;
    clr_mask = '0;
    if (set_en)
      set_mask[set_addr] = 1'b1;
    if (clr_en && clr_addr != '0)
      clr_mask[clr_addr] = 1'b1;
    // Set is applied after clear so it wins on a same-index collision
    pend_next    = (pend & ~clr_mask) | set_mask;
    pend_next[0] = 1'b0;
  end

  // Pending-write register
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst)
      pend <= '0;
    else
      pend <= pend_next;
  end

  // Hazard lookup on the registered vector only; no same-cycle bypass
  always_comb begin
    hazard = (uses_rs    & pend[rs_addr])
           | (uses_rt    & pend[rt_addr])
           | (check_dest & pend[dest_addr]);
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: accepts an instruction, reads rs/rt from the
// register file, stalls on pending writes and hands a held operand bundle
// to execute over a valid/ready handshake.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] read_address_0,
  output logic [ADDR_W-1:0] read_address_1,
  input  logic [DATA_W-1:0] read_data_0,
  input  logic [DATA_W-1:0] read_data_1,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [31:0]       op_imm,
  output logic [5:0]        op_opcode,
  output logic [5:0]        op_funct,
  output logic [ADDR_W-1:0] op_dest,
  output logic              op_writes,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr
);

  state_t            state_q;
  state_t            state_d;
  logic [31:0]       ir;
  decode_t           dec;
  logic [ADDR_W-1:0] dest;
  logic              writes;
  logic              hazard;
  logic              accept;
  logic              latch;

  // Decode of the held instruction word
  always_comb begin
    dec    = decode_instr(ir);
    dest   = ADDR_W'(dec.dest);
    writes = dec.has_dest & (dest != '0);
  end

  assign read_address_0 = ir[RS_LSB +: ADDR_W];
  assign read_address_1 = ir[RT_LSB +: ADDR_W];
  assign accept         = instr_valid & instr_ready;
  assign latch          = (state_q == READ) & ~hazard;

  scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (latch & writes),
    .set_addr   (dest),
    .clr_en     (wb_en),
    .clr_addr   (wb_addr),
    .rs_addr    (read_address_0),
    .uses_rs    (dec.uses_rs),
    .rt_addr    (read_address_1),
    .uses_rt    (dec.uses_rt),
    .dest_addr  (dest),
    .check_dest (writes),
    .hazard     (hazard)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (!hazard) state_d = VALID;
      VALID:   if (op_ready) state_d = instr_valid ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; instr_ready in VALID follows op_ready for back-to-back issue
  always_comb begin
    instr_ready = 1'b0;
    op_valid    = 1'b0;
    case (state_q)
      IDLE:    instr_ready = ~rst;
      VALID: begin
        op_valid    = 1'b1;
        instr_ready = op_ready & ~rst;
      end
      default: ;
    endcase
  end

  // Instruction register and operand bundle; the bundle only moves on READ->VALID
  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_imm    <= '0;
      op_opcode <= '0;
      op_funct  <= '0;
      op_dest   <= '0;
      op_writes <= 1'b0;
    end else begin
      if (accept)
        ir <= instr;
      if (latch) begin
        op_a      <= read_data_0;
        op_b      <= read_data_1;
        op_imm    <= {{(32 - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
        op_opcode <= ir[OPC_LSB +: OPC_W];
        op_funct  <= ir[FUNCT_W-1:0];
        op_dest   <= dest;
        op_writes <= writes;
      end
    end
  end

endmodule
